// File: rtl/hazard_ctrl_pkg.sv
// Shared constants, shadow-stage records and the forward/stall helper functions
// used by the pipeline hazard controller.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] TNEW_JAL  = 2'd0;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

    typedef struct packed {
        logic [4:0] a3;
        logic [1:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       md_start;
        logic       md_div;
    } e_stage_t;

    typedef struct packed {
        logic [4:0] a3;
        logic [1:0] tnew;
        logic [4:0] rt;
    } m_stage_t;

    typedef struct packed {
        logic [4:0] a3;
        logic [1:0] tnew;
    } w_stage_t;

    // Youngest matching producer wins; it is only bypassed once its result exists.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] r,
        input logic       scan_e,
        input logic [4:0] e_a3,
        input logic [1:0] e_tnew,
        input logic       scan_m,
        input logic [4:0] m_a3,
        input logic [1:0] m_tnew,
        input logic [4:0] w_a3,
        input logic [1:0] w_tnew
    );
        fwd_sel = FWD_RF;
        if (r != 5'd0) begin
            if (scan_e && e_a3 == r) begin
                fwd_sel = (e_tnew == TNEW_JAL) ? FWD_E : FWD_RF;
            end else if (scan_m && m_a3 == r) begin
                fwd_sel = (m_tnew == TNEW_JAL) ? FWD_M : FWD_RF;
            end else if (w_a3 == r) begin
                fwd_sel = (w_tnew == TNEW_JAL) ? FWD_W : FWD_RF;
            end
        end
    endfunction

    function automatic logic reg_hazard(
        input logic [4:0] r,
        input logic [1:0] tuse,
        input logic [4:0] e_a3,
        input logic [1:0] e_tnew,
        input logic [4:0] m_a3,
        input logic [1:0] m_tnew
    );
        reg_hazard = 1'b0;
        if (tuse != TUSE_NONE && r != 5'd0) begin
            if (e_a3 == r) begin
                reg_hazard = (tuse < e_tnew);
            end else if (m_a3 == r) begin
                reg_hazard = (tuse < m_tnew);
            end
        end
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_ctr.sv
// Busy counter for the multi-cycle HI/LO unit: loads on a mult/div leaving E,
// then counts down to idle.
module md_busy_ctr #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic load_div,
    output logic busy
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/forwarding controller: tracks a shadow copy of E/M/W destination
// registers and Tnew, and drives stall, E bubble, bypass selects and HI/LO busy.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_a3,
    input  logic [1:0] d_tnew,
    input  logic       d_md_start,
    input  logic       d_md_div,
    input  logic       d_md_use,
    output logic       stall,
    output logic       flush_e,
    output logic [1:0] fwd_d_rs,
    output logic [1:0] fwd_d_rt,
    output logic [1:0] fwd_e_rs,
    output logic [1:0] fwd_e_rt,
    output logic [1:0] fwd_m_rt,
    output logic       md_busy
);

    e_stage_t e_q;
    m_stage_t m_q;
    w_stage_t w_q;

    logic hazard_rs;
    logic hazard_rt;
    logic hazard_md;

    always_comb begin
        hazard_rs = reg_hazard(d_rs, d_tuse_rs, e_q.a3, e_q.tnew, m_q.a3, m_q.tnew);
        hazard_rt = reg_hazard(d_rt, d_tuse_rt, e_q.a3, e_q.tnew, m_q.a3, m_q.tnew);
        // A mult/div sitting in E has not loaded the counter yet, so it blocks too.
        hazard_md = d_md_use & (md_busy | e_q.md_start);
    end

    assign stall   = hazard_rs | hazard_rt | hazard_md;
    assign flush_e = stall;

    always_comb begin
        fwd_d_rs = fwd_sel(d_rs, 1'b1, e_q.a3, e_q.tnew, 1'b1, m_q.a3, m_q.tnew, w_q.a3, w_q.tnew);
        fwd_d_rt = fwd_sel(d_rt, 1'b1, e_q.a3, e_q.tnew, 1'b1, m_q.a3, m_q.tnew, w_q.a3, w_q.tnew);
        fwd_e_rs = fwd_sel(e_q.rs, 1'b0, e_q.a3, e_q.tnew, 1'b1, m_q.a3, m_q.tnew, w_q.a3, w_q.tnew);
        fwd_e_rt = fwd_sel(e_q.rt, 1'b0, e_q.a3, e_q.tnew, 1'b1, m_q.a3, m_q.tnew, w_q.a3, w_q.tnew);
        fwd_m_rt = fwd_sel(m_q.rt, 1'b0, e_q.a3, e_q.tnew, 1'b0, m_q.a3, m_q.tnew, w_q.a3, w_q.tnew);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            w_q <= {m_q.a3, m_q.tnew};
            m_q <= {e_q.a3, (e_q.tnew == TNEW_JAL) ? TNEW_JAL : (e_q.tnew - 2'd1), e_q.rt};
            if (stall) begin
                e_q <= '0;
            end else begin
                e_q <= {d_a3, d_tnew, d_rs, d_rt, d_md_start, d_md_div};
            end
        end
    end

    md_busy_ctr #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_md_busy_ctr (
        .clk     (clk),
        .reset   (reset),
        .load    (e_q.md_start),
        .load_div(e_q.md_div),
        .busy    (md_busy)
    );

endmodule
